// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_controller slice: FSM state codes, opcode and
// ALU op constants, register-select codes, instruction classes.
package cpu_pkg;

    localparam int IW = 16;
    localparam int NR = 3;

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_GET_A  = 3'd2;
    localparam logic [2:0] S_GET_B  = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WR_REG = 3'd5;
    localparam logic [2:0] S_WR_IMM = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    // Encoding shared with the ALU.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    typedef enum logic [2:0] {
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ALU,
        CLS_CMP,
        CLS_MVN,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic logic [IW-1:0] sext8(input logic [7:0] imm);
        return {{(IW-8){imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction for the latched instruction: ALU op, shift,
// sign-extended immediate, legality and instruction class.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [IW-1:0] ir,
    output logic [1:0]    op,
    output logic [1:0]    sh,
    output logic [IW-1:0] sximm8,
    output logic          legal,
    output instr_class_e  cls
);

    logic [2:0] opcode;
    logic       unused_rn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign sh     = ir[4:3];
    assign sximm8 = sext8(ir[7:0]);

    // Register indices go straight from the instruction register to the datapath.
    assign unused_rn = ^ir[8 +: NR];

    always_comb begin
        // NOTE: assign a default before the case so no path leaves cls unassigned (no latch).
        cls = CLS_ILLEGAL;
        if (opcode == OP_MOV) begin
            if (op == 2'b10)
                cls = CLS_MOV_IMM;
            else if (op == 2'b00)
                cls = CLS_MOV_REG;
        end else if (opcode == OP_ALU) begin
            case (op)
                ALU_ADD, ALU_AND: cls = CLS_ALU;
                ALU_SUB:          cls = CLS_CMP;
                default:          cls = CLS_MVN;
            endcase
        end
    end

    assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: latches one instruction and steps a Moore FSM driving
// the datapath. Define CPU_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [IW-1:0] instr,
    output logic          ready,
    output logic          done,
    output logic [2:0]    nsel,
    output logic          vsel,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic [1:0]    alu_op,
    output logic [1:0]    shift,
    output logic [IW-1:0] sximm8,
    output logic          err
);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [IW-1:0] ir;
    logic [1:0]    op;
    logic [1:0]    sh;
    logic          legal;
    instr_class_e  cls;

    instr_decoder u_dec (
        .ir     (ir),
        .op     (op),
        .sh     (sh),
        .sximm8 (sximm8),
        .legal  (legal),
        .cls    (cls)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && start)
                ir <= instr;
        end
    end

    always_comb begin
        state_nxt = S_WAIT;
        case (state)
            S_WAIT:   state_nxt = start ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:          state_nxt = S_WR_IMM;
                    CLS_MOV_REG, CLS_MVN: state_nxt = S_GET_B;
                    CLS_ALU, CLS_CMP:     state_nxt = S_GET_A;
                    default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                        state_nxt = legal ? S_WAIT : S_ERR;
`else
                        state_nxt = S_WAIT;
`endif
                    end
                endcase
            end
            S_GET_A:  state_nxt = S_GET_B;
            S_GET_B:  state_nxt = S_EXEC;
            S_EXEC:   state_nxt = (cls == CLS_CMP) ? S_WAIT : S_WR_REG;
            S_ERR:    state_nxt = S_ERR;
            default:  state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        done   = 1'b0;
        nsel   = NSEL_NONE;
        vsel   = 1'b0;
        write  = 1'b0;
        loada  = 1'b0;
        loadb  = 1'b0;
        loadc  = 1'b0;
        loads  = 1'b0;
        asel   = 1'b0;
        alu_op = ALU_ADD;
        shift  = 2'b00;
        case (state)
            S_WAIT:   ready = 1'b1;
            S_DECODE: begin
`ifndef CPU_CTRL_ILLEGAL_TRAP_EN
                // Illegal instructions retire here as a one-cycle NOP.
                done = !legal;
`endif
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_EXEC: begin
                asel   = (cls == CLS_MOV_REG);
                alu_op = (cls == CLS_MOV_REG) ? ALU_ADD : op;
                shift  = sh;
                loadc  = (cls != CLS_CMP);
                loads  = (cls == CLS_CMP);
                done   = (cls == CLS_CMP);
            end
            S_WR_REG: begin
                nsel  = NSEL_RD;
                write = 1'b1;
                done  = 1'b1;
            end
            S_WR_IMM: begin
                nsel  = NSEL_RN;
                vsel  = 1'b1;
                write = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign err = (state == S_ERR);
`else
    assign err = 1'b0;
`endif

endmodule
